// File: rtl/steering_pkg.sv
// ============================================================================
// steering_pkg : shared encodings and width helpers for the steering controller
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package steering_pkg;

  // The state register doubles as the command, so one encoding serves both.
  typedef enum logic [1:0] {
    CMD_STOP  = 2'b00,
    CMD_LEFT  = 2'b01,
    CMD_RIGHT = 2'b10,
    CMD_FWD   = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    REQ_STOP  = 2'b00,
    REQ_LEFT  = 2'b01,
    REQ_RIGHT = 2'b10,
    REQ_FWD   = 2'b11
  } req_t;

  localparam int SENSOR_W = 5;

  function automatic int cnt_width(input int debounce);
    return (debounce > 1) ? $clog2(debounce) : 1;
  endfunction

  function automatic int hold_width(input int min_hold);
    return (min_hold > 1) ? $clog2(min_hold) : 1;
  endfunction

  function automatic cmd_t req_target(input req_t req);
    cmd_t target;
    case (req)
      REQ_LEFT:  target = CMD_LEFT;
      REQ_RIGHT: target = CMD_RIGHT;
      REQ_FWD:   target = CMD_FWD;
      default:   target = CMD_STOP;
    endcase
    return target;
  endfunction

endpackage

`default_nettype wire

// File: rtl/steering.sv
// ============================================================================
// steering : combinational line-sensor decoder (outer pairs steer, centre walks)
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module steering (
  input  logic [4:0] sensors,
  output logic       left,
  output logic       right,
  output logic       walk
);

  assign left  = sensors[4] | sensors[3];
  assign right = sensors[1] | sensors[0];
  assign walk  = sensors[2];

endmodule

`default_nettype wire

// File: rtl/steering_debounce.sv
// ============================================================================
// steering_debounce : accepts a sensor vector after DEBOUNCE identical samples
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module steering_debounce
  import steering_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SENSOR_W-1:0] in,
  output logic [SENSOR_W-1:0] out
);

  localparam int CW = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  logic [SENSOR_W-1:0] cand;
  logic [CW-1:0]       cnt;

  // cnt holds how many consecutive samples have matched cand so far.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand <= '0;
      cnt  <= '0;
      out  <= '0;
    end else if (in != cand) begin
      cand <= in;
      cnt  <= CW'(1);
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end else begin
      out <= cand;
    end
  end

endmodule

`default_nettype wire

// File: rtl/steering_ctrl.sv
// ============================================================================
// steering_ctrl : debounced sensor decode, direction FSM and motor handshake
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module steering_ctrl
  import steering_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int MIN_HOLD = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SENSOR_W-1:0] sensors,
  input  logic                cmd_ready,
  output logic                cmd_valid,
  output logic [1:0]          cmd,
  output logic                turning,
  output logic [SENSOR_W-1:0] stable_sensors
);

  localparam int HW = hold_width(MIN_HOLD);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_HOLD - 1);

  cmd_t          state;
  cmd_t          state_next;
  req_t          req;
  logic          state_change;
  logic [HW-1:0] hold;
  logic          dec_left;
  logic          dec_right;
  logic          dec_walk;

  steering_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .in    (sensors),
    .out   (stable_sensors)
  );

  steering u_steering (
    .sensors (stable_sensors),
    .left    (dec_left),
    .right   (dec_right),
    .walk    (dec_walk)
  );

  always_comb begin
    req = REQ_STOP;
    if (dec_left && !dec_right) begin
      req = REQ_LEFT;
    end else if (dec_right && !dec_left) begin
      req = REQ_RIGHT;
    end else if (!dec_left && !dec_right && dec_walk) begin
      req = REQ_FWD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CMD_STOP;
    end else begin
      state <= state_next;
    end
  end

  // The FSM is frozen while a command is outstanding so cmd stays stable.
  always_comb begin
    state_next = state;
    if (!cmd_valid) begin
      unique case (state)
        CMD_STOP, CMD_FWD: begin
          state_next = req_target(req);
        end
        CMD_LEFT, CMD_RIGHT: begin
          if (req == REQ_STOP) begin
            state_next = CMD_STOP;
          end else if (hold == '0) begin
            if (req == REQ_FWD) begin
              state_next = CMD_FWD;
            end else if (req_target(req) != state) begin
              state_next = CMD_STOP;
            end
          end
        end
        default: state_next = CMD_STOP;
      endcase
    end
  end

  assign state_change = (state_next != state);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_valid <= 1'b0;
    end else if (state_change) begin
      cmd_valid <= 1'b1;
    end else if (cmd_ready) begin
      cmd_valid <= 1'b0;
    end
  end

  // Hold keeps counting down while a turn command awaits acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold <= '0;
    end else if (state_change &&
                 ((state_next == CMD_LEFT) || (state_next == CMD_RIGHT))) begin
      hold <= HOLD_LOAD;
    end else if (hold != '0) begin
      hold <= hold - 1'b1;
    end
  end

  assign cmd     = state;
  assign turning = (state == CMD_LEFT) || (state == CMD_RIGHT);

endmodule

`default_nettype wire
